// File: rtl/tlb_mp_if.sv
// tlb_mp_if -- bundle of every tlb_mp signal except clk/reset.
//   master : driven by the requester (search ports, write/read, invalidate)
//   slave  : the TLB itself
// Search port p occupies slice p of each per-port vector (port 0 in the LSBs).
// Entry packing (89 bits, MSB first):
//   {e, vppn[18:0], ps[5:0], asid[9:0], g,
//    ppn0[19:0], plv0[1:0], mat0[1:0], d0, v0,
//    ppn1[19:0], plv1[1:0], mat1[1:0], d1, v1}
interface tlb_mp_if #(
   parameter int TLBNUM = 16,
   parameter int NPORT  = 2
);
   localparam int IW = $clog2(TLBNUM);

   // search ports
   logic [NPORT-1:0]      s_req;
   logic [NPORT*19-1:0]   s_vppn;
   logic [NPORT-1:0]      s_va_bit12;
   logic [NPORT*10-1:0]   s_asid;
   logic [NPORT-1:0]      s_rvalid;
   logic [NPORT-1:0]      s_found;
   logic [NPORT*IW-1:0]   s_index;
   logic [NPORT*20-1:0]   s_ppn;
   logic [NPORT*6-1:0]    s_ps;
   logic [NPORT*6-1:0]    s_attr;
   // write / read / replacement
   logic                  we;
   logic [IW-1:0]         w_index;
   logic [88:0]           w_entry;
   logic [IW-1:0]         r_index;
   logic [88:0]           r_entry;
   logic [IW-1:0]         fill_index;
   // invalidate
   logic                  inv_valid;
   logic                  inv_ready;
   logic [4:0]            inv_op;
   logic [9:0]            inv_asid;
   logic [18:0]           inv_vppn;
   logic                  inv_err;
   // statistics
   logic [31:0]           hit_cnt;
   logic [31:0]           miss_cnt;

   modport master (
      output s_req, s_vppn, s_va_bit12, s_asid,
      input  s_rvalid, s_found, s_index, s_ppn, s_ps, s_attr,
      output we, w_index, w_entry, r_index,
      input  r_entry, fill_index,
      output inv_valid, inv_op, inv_asid, inv_vppn,
      input  inv_ready, inv_err, hit_cnt, miss_cnt
   );

   modport slave (
      input  s_req, s_vppn, s_va_bit12, s_asid,
      output s_rvalid, s_found, s_index, s_ppn, s_ps, s_attr,
      input  we, w_index, w_entry, r_index,
      output r_entry, fill_index,
      input  inv_valid, inv_op, inv_asid, inv_vppn,
      output inv_ready, inv_err, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/tlb_mp.sv
// tlb_mp -- fully associative TLB with NPORT search ports, one write port,
// a combinational read port, a TLBINV-style invalidate engine and a
// free-running replacement index.
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : tlb_mp_if.slave (search, write/read, invalidate, statistics)
// Configuration macro: TLB_STAT_EN -- when defined, hit_cnt/miss_cnt count
// hitting/missing requesting ports per cycle (saturating); otherwise both
// outputs are tied to zero.
module tlb_mp #(
   parameter int TLBNUM = 16,
   parameter int NPORT  = 2
) (
   input logic     clk,
   input logic     reset,
   tlb_mp_if.slave bus
);
   localparam int IW = $clog2(TLBNUM);

   typedef enum logic {ST_IDLE, ST_APPLY} inv_state_e;

   // entry storage; only e is reset, the rest keeps its contents
   logic [TLBNUM-1:0] r_e, r_g, r_ps4m;
   logic [18:0]       r_vppn  [TLBNUM];
   logic [9:0]        r_asid  [TLBNUM];
   logic [25:0]       r_half0 [TLBNUM];   // {ppn, plv, mat, d, v}
   logic [25:0]       r_half1 [TLBNUM];

   function automatic logic f_va_match(input logic [18:0] ent_vppn,
                                       input logic ps4m,
                                       input logic [18:0] vppn);
      return (ent_vppn[18:10] == vppn[18:10]) &&
             (ps4m || (ent_vppn[9:0] == vppn[9:0]));
   endfunction

   // ---------------- lookup ----------------
   logic [NPORT-1:0]           w_hit;
   logic [NPORT-1:0][IW-1:0]   w_hit_idx;
   logic [NPORT-1:0][25:0]     w_half;

   always_comb begin
      for (int unsigned p = 0; p < NPORT; p++) begin
         w_hit[p]     = 1'b0;
         w_hit_idx[p] = '0;
         // downward scan: the lowest matching index is assigned last and wins
         for (int unsigned i = TLBNUM; i > 0; i--) begin
            if (r_e[i-1] &&
                f_va_match(r_vppn[i-1], r_ps4m[i-1], bus.s_vppn[p*19 +: 19]) &&
                (r_g[i-1] || (r_asid[i-1] == bus.s_asid[p*10 +: 10]))) begin
               w_hit[p]     = 1'b1;
               w_hit_idx[p] = IW'(i-1);
            end
         end
         // 4MB pages pick the odd half by VA[22] (vppn[9]), 4KB pages by VA[12]
         if (r_ps4m[w_hit_idx[p]] ? bus.s_vppn[p*19+9] : bus.s_va_bit12[p])
            w_half[p] = r_half1[w_hit_idx[p]];
         else
            w_half[p] = r_half0[w_hit_idx[p]];
      end
   end

   logic [NPORT-1:0]          r_rvalid, r_found;
   logic [NPORT-1:0][IW-1:0]  r_idx;
   logic [NPORT-1:0][19:0]    r_ppn;
   logic [NPORT-1:0][5:0]     r_ps, r_attr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rvalid <= '0;
         r_found  <= '0;
         r_idx    <= '0;
         r_ppn    <= '0;
         r_ps     <= '0;
         r_attr   <= '0;
      end else begin
         r_rvalid <= bus.s_req;
         for (int unsigned p = 0; p < NPORT; p++) begin
            if (bus.s_req[p]) begin
               r_found[p] <= w_hit[p];
               r_idx[p]   <= w_hit[p] ? w_hit_idx[p] : '0;
               r_ppn[p]   <= w_hit[p] ? w_half[p][25:6] : '0;
               r_attr[p]  <= w_hit[p] ? w_half[p][5:0] : '0;
               r_ps[p]    <= !w_hit[p] ? 6'd0 :
                             (r_ps4m[w_hit_idx[p]] ? 6'd22 : 6'd12);
            end
         end
      end
   end

   // ---------------- invalidate FSM ----------------
   inv_state_e  r_state, w_state_nxt;
   logic        w_inv_ready, w_apply, w_inv_err;
   logic [4:0]  r_inv_op;
   logic [9:0]  r_inv_asid;
   logic [18:0] r_inv_vppn;

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.inv_valid) w_state_nxt = ST_APPLY;
         ST_APPLY: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_inv_ready = (r_state == ST_IDLE);
      w_apply     = (r_state == ST_APPLY);
      w_inv_err   = w_apply && (r_inv_op > 5'd6);
   end

   always_ff @(posedge clk) begin
      if (bus.inv_valid && w_inv_ready) begin
         r_inv_op   <= bus.inv_op;
         r_inv_asid <= bus.inv_asid;
         r_inv_vppn <= bus.inv_vppn;
      end
   end

   logic [TLBNUM-1:0] w_inv_mask;
   always_comb begin
      logic l_asid, l_va;
      for (int unsigned i = 0; i < TLBNUM; i++) begin
         l_asid = (r_asid[i] == r_inv_asid);
         l_va   = f_va_match(r_vppn[i], r_ps4m[i], r_inv_vppn);
         case (r_inv_op)
            5'd0, 5'd1: w_inv_mask[i] = 1'b1;
            5'd2:       w_inv_mask[i] = r_g[i];
            5'd3:       w_inv_mask[i] = !r_g[i];
            5'd4:       w_inv_mask[i] = !r_g[i] && l_asid;
            5'd5:       w_inv_mask[i] = !r_g[i] && l_asid && l_va;
            5'd6:       w_inv_mask[i] = (r_g[i] || l_asid) && l_va;
            default:    w_inv_mask[i] = 1'b0;
         endcase
      end
   end

   // ---------------- entry update ----------------
   // the written entry overrides the invalidate mask when both hit the same cycle
   logic [TLBNUM-1:0] w_e_nxt;
   always_comb begin
      w_e_nxt = w_apply ? (r_e & ~w_inv_mask) : r_e;
      if (bus.we) w_e_nxt[bus.w_index] = bus.w_entry[88];
   end

   always_ff @(posedge clk) begin
      if (reset) r_e <= '0;
      else       r_e <= w_e_nxt;
   end

   always_ff @(posedge clk) begin
      if (bus.we && !reset) begin
         r_vppn[bus.w_index]  <= bus.w_entry[87:69];
         r_ps4m[bus.w_index]  <= (bus.w_entry[68:63] == 6'd22);
         r_asid[bus.w_index]  <= bus.w_entry[62:53];
         r_g[bus.w_index]     <= bus.w_entry[52];
         r_half0[bus.w_index] <= bus.w_entry[51:26];
         r_half1[bus.w_index] <= bus.w_entry[25:0];
      end
   end

   logic [IW-1:0] r_fill;
   always_ff @(posedge clk) begin
      if (reset) r_fill <= '0;
      else       r_fill <= r_fill + 1'b1;
   end

   // ---------------- statistics ----------------
`ifdef TLB_STAT_EN
   logic [31:0] r_hit_cnt, r_miss_cnt;
   logic [2:0]  w_nhit, w_nmiss;
   logic [32:0] w_hit_sum, w_miss_sum;

   always_comb begin
      w_nhit  = '0;
      w_nmiss = '0;
      for (int unsigned p = 0; p < NPORT; p++) begin
         if (bus.s_req[p] && w_hit[p])  w_nhit  = w_nhit + 3'd1;
         if (bus.s_req[p] && !w_hit[p]) w_nmiss = w_nmiss + 3'd1;
      end
      w_hit_sum  = {1'b0, r_hit_cnt} + 33'(w_nhit);
      w_miss_sum = {1'b0, r_miss_cnt} + 33'(w_nmiss);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_hit_cnt  <= w_hit_sum[32]  ? '1 : w_hit_sum[31:0];
         r_miss_cnt <= w_miss_sum[32] ? '1 : w_miss_sum[31:0];
      end
   end

   assign bus.hit_cnt  = r_hit_cnt;
   assign bus.miss_cnt = r_miss_cnt;
`else
   assign bus.hit_cnt  = '0;
   assign bus.miss_cnt = '0;
`endif

   // ---------------- outputs ----------------
   assign bus.s_rvalid   = r_rvalid;
   assign bus.s_found    = r_found;
   assign bus.s_index    = r_idx;
   assign bus.s_ppn      = r_ppn;
   assign bus.s_ps       = r_ps;
   assign bus.s_attr     = r_attr;
   assign bus.fill_index = r_fill;
   assign bus.inv_ready  = w_inv_ready;
   assign bus.inv_err    = w_inv_err;
   assign bus.r_entry    = {r_e[bus.r_index], r_vppn[bus.r_index],
                            (r_ps4m[bus.r_index] ? 6'd22 : 6'd12),
                            r_asid[bus.r_index], r_g[bus.r_index],
                            r_half0[bus.r_index], r_half1[bus.r_index]};
endmodule

// File: tb/tb_tlb_mp.sv
// tb_tlb_mp -- directed self-checking bench for tlb_mp (TLBNUM=16, NPORT=2).
// Counter expectations follow TLB_STAT_EN so the bench works in both builds.
module tb_tlb_mp;
   localparam logic [5:0] ATTR0 = 6'b000111;  // plv0=0 mat0=1 d0=1 v0=1
   localparam logic [5:0] ATTR1 = 6'b111001;  // plv1=3 mat1=2 d1=0 v1=1

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   tlb_mp_if #(.TLBNUM(16), .NPORT(2)) bus ();

   tlb_mp #(.TLBNUM(16), .NPORT(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [88:0] mk(input logic e, input logic [18:0] vppn,
                                      input logic [5:0] ps, input logic [9:0] asid,
                                      input logic g, input logic [19:0] ppn0,
                                      input logic [19:0] ppn1);
      return {e, vppn, ps, asid, g, ppn0, ATTR0, ppn1, ATTR1};
   endfunction

   task automatic wr(input int idx, input logic [88:0] ent);
      bus.we      = 1'b1;
      bus.w_index = 4'(idx);
      bus.w_entry = ent;
      tick();
      bus.we      = 1'b0;
   endtask

   task automatic rd(input int idx, output logic [88:0] ent);
      bus.r_index = 4'(idx);
      #1;
      ent = bus.r_entry;
   endtask

   task automatic lk(input logic [1:0] req,
                     input logic [18:0] v0, input logic b0, input logic [9:0] a0,
                     input logic [18:0] v1, input logic b1, input logic [9:0] a1);
      bus.s_req      = req;
      bus.s_vppn     = {v1, v0};
      bus.s_va_bit12 = {b1, b0};
      bus.s_asid     = {a1, a0};
      tick();
      bus.s_req      = '0;
   endtask

   task automatic chk_res(input string tag, input int p, input logic found,
                          input logic [3:0] idx, input logic [19:0] ppn,
                          input logic [5:0] ps, input logic [5:0] attr);
      check({tag, ".found"}, 64'(bus.s_found[p]), 64'(found));
      check({tag, ".index"}, 64'(bus.s_index[p*4 +: 4]), 64'(idx));
      check({tag, ".ppn"},   64'(bus.s_ppn[p*20 +: 20]), 64'(ppn));
      check({tag, ".ps"},    64'(bus.s_ps[p*6 +: 6]), 64'(ps));
      check({tag, ".attr"},  64'(bus.s_attr[p*6 +: 6]), 64'(attr));
   endtask

   initial begin
      logic [88:0] ent;
      int          inv_idx [6] = '{1, 4, 6, 3, 7, 5};
      logic        inv_e   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

      reset          = 1'b1;
      bus.s_req      = '0;
      bus.s_vppn     = '0;
      bus.s_va_bit12 = '0;
      bus.s_asid     = '0;
      bus.we         = 1'b0;
      bus.w_index    = '0;
      bus.w_entry    = '0;
      bus.r_index    = '0;
      bus.inv_valid  = 1'b0;
      bus.inv_op     = '0;
      bus.inv_asid   = '0;
      bus.inv_vppn   = '0;

      // reset state
      tick();
      tick();
      check("rst.rvalid", 64'(bus.s_rvalid), 64'd0);
      check("rst.found", 64'(bus.s_found), 64'd0);
      check("rst.fill", 64'(bus.fill_index), 64'd0);
      check("rst.inv_ready", 64'(bus.inv_ready), 64'd1);
      check("rst.inv_err", 64'(bus.inv_err), 64'd0);
      check("rst.hit_cnt", 64'(bus.hit_cnt), 64'd0);
      check("rst.miss_cnt", 64'(bus.miss_cnt), 64'd0);
      rd(0, ent);
      check("rst.e0", 64'(ent[88]), 64'd0);
      reset = 1'b0;

      // fill_index counts every cycle and wraps 15 -> 0
      repeat (15) tick();
      check("fill.15", 64'(bus.fill_index), 64'd15);
      tick();
      check("fill.wrap", 64'(bus.fill_index), 64'd0);

      // basic 4KB hit, odd half on port 0, even half on port 1
      wr(3, mk(1'b1, 19'h12345, 6'd12, 10'd5, 1'b0, 20'h00100, 20'h00200));
      lk(2'b11, 19'h12345, 1'b1, 10'd5, 19'h12345, 1'b0, 10'd5);
      check("basic.rvalid", 64'(bus.s_rvalid), 64'd3);
      chk_res("basic.p0", 0, 1'b1, 4'd3, 20'h00200, 6'd12, ATTR1);
      chk_res("basic.p1", 1, 1'b1, 4'd3, 20'h00100, 6'd12, ATTR0);
      tick();
      check("hold.rvalid", 64'(bus.s_rvalid), 64'd0);
      check("hold.found", 64'(bus.s_found[0]), 64'd1);
      check("hold.ppn", 64'(bus.s_ppn[19:0]), 64'h00200);

      // two matching entries -> lowest index; wrong ASID -> all-zero miss
      wr(2, mk(1'b1, 19'h0ABCD, 6'd12, 10'd9, 1'b0, 20'h00222, 20'h00223));
      wr(7, mk(1'b1, 19'h0ABCD, 6'd12, 10'd9, 1'b0, 20'h00777, 20'h00778));
      lk(2'b11, 19'h0ABCD, 1'b0, 10'd9, 19'h0ABCD, 1'b0, 10'd6);
      chk_res("multi.p0", 0, 1'b1, 4'd2, 20'h00222, 6'd12, ATTR0);
      chk_res("miss.p1", 1, 1'b0, 4'd0, 20'h0, 6'd0, 6'd0);

      // lookup in the same cycle as a write sees the old entry 2
      bus.we      = 1'b1;
      bus.w_index = 4'd2;
      bus.w_entry = mk(1'b0, 19'h0ABCD, 6'd12, 10'd9, 1'b0, 20'h00222, 20'h00223);
      lk(2'b01, 19'h0ABCD, 1'b0, 10'd9, 19'h0, 1'b0, 10'd0);
      bus.we      = 1'b0;
      check("wrpre.index", 64'(bus.s_index[3:0]), 64'd2);
      lk(2'b01, 19'h0ABCD, 1'b0, 10'd9, 19'h0, 1'b0, 10'd0);
      chk_res("wrpost.p0", 0, 1'b1, 4'd7, 20'h00777, 6'd12, ATTR0);

      // 4MB page: vppn[9] selects half, low vppn bits and va_bit12 ignored
      wr(5, mk(1'b1, 19'h06800, 6'd22, 10'd3, 1'b1, 20'h00333, 20'h00444));
      lk(2'b11, 19'h06A05, 1'b0, 10'd0, 19'h06805, 1'b1, 10'h3FF);
      chk_res("big.p0", 0, 1'b1, 4'd5, 20'h00444, 6'd22, ATTR1);
      chk_res("big.p1", 1, 1'b1, 4'd5, 20'h00333, 6'd22, ATTR0);
      rd(5, ent);
      check("rd5.e", 64'(ent[88]), 64'd1);
      check("rd5.ps", 64'(ent[68:63]), 64'd22);
      wr(9, mk(1'b0, 19'h7FFFF, 6'd14, 10'd0, 1'b0, 20'h0, 20'h0));
      rd(9, ent);
      check("rd9.ps", 64'(ent[68:63]), 64'd12);
      check("rd9.e", 64'(ent[88]), 64'd0);

      // invalidate op 4 asid 5: clears g=0 asid-5 entries (1,3,4), keeps 6,7,5
      wr(1, mk(1'b1, 19'h01001, 6'd12, 10'd5, 1'b0, 20'h00011, 20'h00012));
      wr(4, mk(1'b1, 19'h01004, 6'd12, 10'd5, 1'b0, 20'h00041, 20'h00042));
      wr(6, mk(1'b1, 19'h01006, 6'd12, 10'd5, 1'b1, 20'h00061, 20'h00062));
      bus.inv_valid = 1'b1;
      bus.inv_op    = 5'd4;
      bus.inv_asid  = 10'd5;
      bus.inv_vppn  = 19'h0;
      #1;
      check("inv4.ready_idle", 64'(bus.inv_ready), 64'd1);
      tick();
      bus.inv_valid = 1'b0;
      check("inv4.ready_apply", 64'(bus.inv_ready), 64'd0);
      check("inv4.err", 64'(bus.inv_err), 64'd0);
      lk(2'b01, 19'h01001, 1'b0, 10'd5, 19'h0, 1'b0, 10'd0);
      check("inv4.ready_back", 64'(bus.inv_ready), 64'd1);
      chk_res("invpre.p0", 0, 1'b1, 4'd1, 20'h00011, 6'd12, ATTR0);
      for (int k = 0; k < 6; k++) begin
         rd(inv_idx[k], ent);
         check($sformatf("inv4.e%0d", inv_idx[k]), 64'(ent[88]), 64'(inv_e[k]));
      end
      lk(2'b01, 19'h01001, 1'b0, 10'd5, 19'h0, 1'b0, 10'd0);
      chk_res("invpost.p0", 0, 1'b0, 4'd0, 20'h0, 6'd0, 6'd0);

      // unsupported op 9: one-cycle error pulse, nothing cleared
      bus.inv_valid = 1'b1;
      bus.inv_op    = 5'd9;
      tick();
      bus.inv_valid = 1'b0;
      check("inv9.err", 64'(bus.inv_err), 64'd1);
      tick();
      check("inv9.err_end", 64'(bus.inv_err), 64'd0);
      rd(6, ent);
      check("inv9.e6", 64'(ent[88]), 64'd1);
      rd(7, ent);
      check("inv9.e7", 64'(ent[88]), 64'd1);

      // op 0 with a concurrent write: written entry survives, others cleared
      bus.inv_valid = 1'b1;
      bus.inv_op    = 5'd0;
      tick();
      bus.inv_valid = 1'b0;
      wr(10, mk(1'b1, 19'h05555, 6'd12, 10'd1, 1'b0, 20'h000A1, 20'h000A2));
      rd(10, ent);
      check("wrapply.e10", 64'(ent[88]), 64'd1);
      rd(6, ent);
      check("wrapply.e6", 64'(ent[88]), 64'd0);
      rd(5, ent);
      check("wrapply.e5", 64'(ent[88]), 64'd0);

      // reset while APPLY is pending
      bus.inv_valid = 1'b1;
      bus.inv_op    = 5'd2;
      tick();
      bus.inv_valid = 1'b0;
      check("rstapply.ready_apply", 64'(bus.inv_ready), 64'd0);
      reset = 1'b1;
      tick();
      check("rstapply.ready", 64'(bus.inv_ready), 64'd1);
      check("rstapply.fill", 64'(bus.fill_index), 64'd0);
      check("rstapply.rvalid", 64'(bus.s_rvalid), 64'd0);
      check("rstapply.found", 64'(bus.s_found), 64'd0);
      rd(10, ent);
      check("rstapply.e10", 64'(ent[88]), 64'd0);
      check("rstapply.vppn10", 64'(ent[87:69]), 64'h05555);
      reset = 1'b0;

      // statistics: two ports hit for 3 cycles, then one miss on port 0
      wr(10, mk(1'b1, 19'h05555, 6'd12, 10'd1, 1'b0, 20'h000A1, 20'h000A2));
      repeat (3) lk(2'b11, 19'h05555, 1'b0, 10'd1, 19'h05555, 1'b1, 10'd1);
      chk_res("stat.p1", 1, 1'b1, 4'd10, 20'h000A2, 6'd12, ATTR1);
      lk(2'b01, 19'h05555, 1'b0, 10'd2, 19'h0, 1'b0, 10'd0);
      check("stat.miss_found", 64'(bus.s_found[0]), 64'd0);
`ifdef TLB_STAT_EN
      check("stat.hit_cnt", 64'(bus.hit_cnt), 64'd6);
      check("stat.miss_cnt", 64'(bus.miss_cnt), 64'd1);
`else
      check("stat.hit_cnt", 64'(bus.hit_cnt), 64'd0);
      check("stat.miss_cnt", 64'(bus.miss_cnt), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
